// File: rtl/jk_cnt_pkg.sv
// Shared types and JK excitation codes for the JK-cell target counter.
package jk_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DONE
  } cnt_state_e;

  // {j, k} excitation codes
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop with asynchronous active-high clear.
module jk_ff_cell
  import jk_cnt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD:   q <= q;
        JK_RESET:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        JK_TOGGLE: q <= ~q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_target_counter.sv
// Up-counter built from JK cells: counts enabled cycles to a latched target,
// then clears to zero and pulses hit.
module jk_target_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             en,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             hit,
  output logic             done
);

  cnt_state_e             state, state_next;
  logic [WIDTH-1:0]       tgt_q;
  logic [WIDTH-1:0]       qbar;
  logic [WIDTH-1:0]       carry;
  logic [WIDTH-1:0]       bit_eq;
  logic [WIDTH-1:0][1:0]  jk;
  logic                   match;
  logic                   clr_all;
  logic                   increment;
  logic                   load_tgt;
  logic                   fire_hit;

  always_comb begin
    state_next = state;
    clr_all    = 1'b0;
    load_tgt   = 1'b0;
    fire_hit   = 1'b0;
    increment  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clr_all    = 1'b1;
          load_tgt   = 1'b1;
          state_next = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // abort outranks both enable and the terminal-count match
        if (abort) begin
          clr_all    = 1'b1;
          state_next = ST_IDLE;
        end else if (en && match) begin
          clr_all    = 1'b1;
          fire_hit   = 1'b1;
          state_next = AUTO_RELOAD ? ST_COUNT : ST_DONE;
        end else if (en) begin
          increment  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign carry[gi] = 1'b1;
      end else begin : g_upper
        assign carry[gi] = &count[gi-1:0];
      end

      // Equality per bit taken straight from the cell outputs
      assign bit_eq[gi] = tgt_q[gi] ? count[gi] : qbar[gi];

      assign jk[gi] = clr_all                  ? JK_RESET  :
                      (increment && carry[gi]) ? JK_TOGGLE : JK_HOLD;

      jk_ff_cell u_cell (
        .clk  (clk),
        .rst  (rst),
        .j    (jk[gi][1]),
        .k    (jk[gi][0]),
        .q    (count[gi]),
        .qbar (qbar[gi])
      );
    end
  endgenerate

  assign match = &bit_eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      tgt_q <= '0;
      hit   <= 1'b0;
    end else begin
      state <= state_next;
      hit   <= fire_hit;
      if (load_tgt) begin
        tgt_q <= target;
      end
    end
  end

  assign busy = (state == ST_COUNT);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_jk_target_counter.sv
// Scoreboard bench: a behavioural counter model predicts both a one-shot and
// an auto-reload instance each cycle; predictions are queued and popped after the edge.
module tb_jk_target_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] target = '0;

  logic [W-1:0] count_once, count_reload;
  logic         busy_once, busy_reload;
  logic         hit_once, hit_reload;
  logic         done_once, done_reload;

  always #5 clk = ~clk;

  jk_target_counter #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_once (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en), .target(target),
    .count(count_once), .busy(busy_once), .hit(hit_once), .done(done_once)
  );

  jk_target_counter #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_reload (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en), .target(target),
    .count(count_reload), .busy(busy_reload), .hit(hit_reload), .done(done_reload)
  );

  typedef struct {
    int cnt;
    int busy;
    int hit;
    int done;
  } obs_t;

  typedef struct {
    obs_t once;
    obs_t reload;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  // model state: 0 idle, 1 count, 2 done
  int m_state[2];
  int m_cnt[2];
  int m_tgt[2];
  int m_hit[2];

  int test_cnt = 0;
  int fail_cnt = 0;
  int hits_once = 0;
  int hits_reload = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_cnt[i] = 0; m_tgt[i] = 0; m_hit[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input bit reload);
    m_hit[i] = 0;
    if (m_state[i] != 1) begin
      if (start) begin
        m_tgt[i]   = int'(target);
        m_cnt[i]   = 0;
        m_state[i] = 1;
      end
    end else if (abort) begin
      m_cnt[i]   = 0;
      m_state[i] = 0;
    end else if (en) begin
      if (m_cnt[i] == m_tgt[i]) begin
        m_cnt[i]   = 0;
        m_hit[i]   = 1;
        m_state[i] = reload ? 1 : 2;
      end else begin
        m_cnt[i] = (m_cnt[i] + 1) % (1 << W);
      end
    end
  endtask

  function automatic obs_t model_obs(input int i);
    obs_t o;
    o.cnt  = m_cnt[i];
    o.busy = (m_state[i] == 1) ? 1 : 0;
    o.hit  = m_hit[i];
    o.done = (m_state[i] == 2) ? 1 : 0;
    return o;
  endfunction

  task automatic step(input logic s, input logic a, input logic e,
                      input int t, input string tag);
    start  = s;
    abort  = a;
    en     = e;
    target = W'(t);
    model_edge(0, 1'b0);
    model_edge(1, 1'b1);
    exp_q.push_back('{once: model_obs(0), reload: model_obs(1)});
    @(posedge clk);
    #1;
    cur = exp_q.pop_front();
    check_eq({tag, ".once.count"},  int'(count_once),  cur.once.cnt);
    check_eq({tag, ".once.busy"},   int'(busy_once),   cur.once.busy);
    check_eq({tag, ".once.hit"},    int'(hit_once),    cur.once.hit);
    check_eq({tag, ".once.done"},   int'(done_once),   cur.once.done);
    check_eq({tag, ".rel.count"},   int'(count_reload), cur.reload.cnt);
    check_eq({tag, ".rel.busy"},    int'(busy_reload),  cur.reload.busy);
    check_eq({tag, ".rel.hit"},     int'(hit_reload),   cur.reload.hit);
    check_eq({tag, ".rel.done"},    int'(done_reload),  cur.reload.done);
    if (hit_once)   hits_once++;
    if (hit_reload) hits_reload++;
    $display("[TB] %-8s s=%0b a=%0b en=%0b tgt=%0d | once cnt=%0d hit=%0b done=%0b | rel cnt=%0d hit=%0b",
             tag, s, a, e, t, count_once, hit_once, done_once, count_reload, hit_reload);
    start = 1'b0;
    abort = 1'b0;
    en    = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_eq("rst.count", int'(count_once), 0);
    check_eq("rst.busy",  int'(busy_once),  0);
    check_eq("rst.hit",   int'(hit_once),   0);
    check_eq("rst.done",  int'(done_once),  0);
    rst = 1'b0;

    // target 3, continuous enable
    step(1, 0, 0, 3, "t3_arm");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, "t3_run");
    step(0, 0, 1, 0, "t3_idle");

    // target 3, enable alternating
    step(1, 0, 0, 3, "alt_arm");
    hits_once = 0;
    for (int i = 0; i < 10; i++) step(0, 0, (i % 2) == 0, 0, "alt_run");
    check_eq("alt.hits", hits_once, 1);

    // target 0 then full-scale target
    step(1, 0, 0, 0, "t0_arm");
    step(0, 0, 1, 0, "t0_run");
    step(0, 0, 1, 0, "t0_after");
    step(1, 0, 0, 15, "t15_arm");
    hits_once = 0;
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0, "t15_run");
    check_eq("t15.hits", hits_once, 1);
    check_eq("t15.count", int'(count_once), 0);

    // auto-reload period: target 2, 9 enabled cycles
    step(0, 1, 0, 0, "ar_abort");
    step(1, 0, 0, 2, "ar_arm");
    hits_reload = 0;
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, "ar_run");
    check_eq("ar.hits", hits_reload, 3);

    // asynchronous reset mid-count at 5
    step(1, 0, 0, 9, "mid_arm");
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, "mid_run");
    #2 rst = 1'b1;
    #1;
    check_eq("async.count", int'(count_once), 0);
    check_eq("async.busy",  int'(busy_once),  0);
    check_eq("async.hit",   int'(hit_once),   0);
    check_eq("async.rel_count", int'(count_reload), 0);
    model_reset();
    #3 rst = 1'b0;

    // abort mid-count, then start ignored while counting
    step(1, 1, 0, 6, "ab_arm");
    step(0, 0, 1, 0, "ab_run");
    step(0, 0, 1, 0, "ab_run");
    step(0, 1, 1, 0, "ab_abort");
    step(1, 0, 0, 6, "ig_arm");
    hits_once = 0;
    step(0, 0, 1, 0, "ig_run");
    step(0, 0, 1, 0, "ig_run");
    step(1, 0, 1, 1, "ig_start");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, "ig_run");
    check_eq("ig.hits", hits_once, 1);
    check_eq("ig.done", int'(done_once), 1);

    check_eq("queue.empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
